// File: rtl/pc_predict_unit.sv
// pc_predict_unit: registered fetch PC with a direct-mapped branch target
// buffer (2-bit saturating counters). Predicts in F, resolves in E, and
// redirects/flushes the front end when the E-stage outcome disagrees.
module pc_predict_unit #(
  parameter int               WIDTH       = 32,
  parameter int               BTB_ENTRIES = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallF,
  input  logic             ValidE,
  input  logic [1:0]       PCSrcE,
  input  logic             ZeroE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic             PredTakenE,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] PCPlus4F,
  output logic             PredTakenF,
  output logic             FlushOut,
  output logic [31:0]      MispredictCnt
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [WIDTH-1:0]       btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]   f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             taken_e, btb_write;
  logic [WIDTH-1:0] target_e, correct_pc, pred_next, next_pc;
  logic             unused_pce_low;

  // The byte offset of the E-stage PC never takes part in BTB indexing.
  assign unused_pce_low = ^PCE[1:0];

  // F-stage lookup: combinational read of the entry selected by PCF.
  assign f_idx      = PCF[IDX+1:2];
  assign f_tag      = PCF[WIDTH-1:IDX+2];
  assign f_hit      = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign PredTakenF = f_hit && btb_ctr[f_idx][1];
  assign PCPlus4F   = PCF + WIDTH'(4);
  assign pred_next  = PredTakenF ? btb_target[f_idx] : PCPlus4F;

  // E-stage resolution: actual outcome compared against the carried prediction.
  assign taken_e    = (PCSrcE == 2'b01) || ((PCSrcE == 2'b10) && ZeroE) || (PCSrcE == 2'b11);
  assign target_e   = (PCSrcE == 2'b11) ? ALUResultE : PCTargetE;
  assign correct_pc = taken_e ? target_e : PCPlus4E;
  assign FlushOut   = ValidE && (taken_e != PredTakenE);

  // Only JAL and conditional branches train the BTB; JALR targets are data dependent.
  assign e_idx     = PCE[IDX+1:2];
  assign e_tag     = PCE[WIDTH-1:IDX+2];
  assign e_hit     = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
  assign btb_write = ValidE && ((PCSrcE == 2'b01) || (PCSrcE == 2'b10));

  // Next-PC select: a redirect beats a stall, a stall beats the prediction.
  always_comb begin
    next_pc = pred_next;
    if (FlushOut) begin
      next_pc = correct_pc;
    end else if (StallF) begin
      next_pc = PCF;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= next_pc;
    end
  end

  // Saturating count of redirect cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MispredictCnt <= '0;
    end else if (FlushOut && (MispredictCnt != 32'hFFFF_FFFF)) begin
      MispredictCnt <= MispredictCnt + 32'd1;
    end
  end

  // Valid bits: cleared by reset, set when a taken miss allocates an entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btb_valid <= '0;
    end else if (btb_write && !e_hit && taken_e) begin
      btb_valid[e_idx] <= 1'b1;
    end
  end

  // Entry payload: train the counter on a hit, overwrite everything on a taken miss.
  always_ff @(posedge clk) begin
    if (btb_write) begin
      if (e_hit) begin
        btb_target[e_idx] <= PCTargetE;
        if (taken_e && (btb_ctr[e_idx] != 2'b11)) begin
          btb_ctr[e_idx] <= btb_ctr[e_idx] + 2'd1;
        end else if (!taken_e && (btb_ctr[e_idx] != 2'b00)) begin
          btb_ctr[e_idx] <= btb_ctr[e_idx] - 2'd1;
        end
      end else if (taken_e) begin
        btb_tag[e_idx]    <= e_tag;
        btb_target[e_idx] <= PCTargetE;
        btb_ctr[e_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: directed scenarios plus randomized traffic for
// pc_predict_unit, checked against a behavioural fetch/BTB model.
module tb_pc_predict_unit;

  localparam int          N        = 4;
  localparam int          L        = $clog2(N);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n, StallF, ValidE, ZeroE, PredTakenE;
  logic [1:0]  PCSrcE;
  logic [31:0] PCE, PCPlus4E, PCTargetE, ALUResultE;
  logic [31:0] PCF, PCPlus4F, MispredictCnt;
  logic        PredTakenF, FlushOut;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_valid  [N];
  logic [31:0] m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];

  pc_predict_unit #(.WIDTH(32), .BTB_ENTRIES(N), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .ValidE(ValidE), .PCSrcE(PCSrcE),
    .ZeroE(ZeroE), .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
    .ALUResultE(ALUResultE), .PredTakenE(PredTakenE), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .PredTakenF(PredTakenF), .FlushOut(FlushOut), .MispredictCnt(MispredictCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (2 + L);
  endfunction

  function automatic bit m_pred();
    int i;
    i = idx_of(m_pc);
    return m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic bit m_taken();
    return (PCSrcE == 2'd1) || ((PCSrcE == 2'd2) && ZeroE) || (PCSrcE == 2'd3);
  endfunction

  function automatic bit m_flush();
    return ValidE && (m_taken() != PredTakenE);
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    logic [31:0] npc, tgt;
    bit pt, tk, fl;
    int fi, ei;
    fi  = idx_of(m_pc);
    pt  = m_pred();
    tk  = m_taken();
    fl  = m_flush();
    tgt = (PCSrcE == 2'd3) ? ALUResultE : PCTargetE;
    if (!rst_n) begin
      m_pc  = RESET_PC;
      m_cnt = 0;
      for (int i = 0; i < N; i++) m_valid[i] = 0;
    end else begin
      if (fl) npc = tk ? tgt : PCPlus4E;
      else if (StallF) npc = m_pc;
      else npc = pt ? m_target[fi] : m_pc + 32'd4;
      if (fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (ValidE && (PCSrcE == 2'd1 || PCSrcE == 2'd2)) begin
        ei = idx_of(PCE);
        if (m_valid[ei] && m_tag[ei] == tag_of(PCE)) begin
          m_ctr[ei]    = tk ? ((m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3)
                            : ((m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0);
          m_target[ei] = PCTargetE;
        end else if (tk) begin
          m_valid[ei]  = 1;
          m_tag[ei]    = tag_of(PCE);
          m_target[ei] = PCTargetE;
          m_ctr[ei]    = 2;
        end
      end
      m_pc = npc;
    end
    @(posedge clk);
    #1;
  endtask

  // Steer fetch to an address with a JALR mispredict from an unrelated PC.
  task automatic redirect(input logic [31:0] addr);
    ValidE = 1; PCSrcE = 2'd3; PredTakenE = 0; StallF = 0;
    PCE = 32'h3C; PCPlus4E = 32'h40; ALUResultE = addr;
    tick();
    ValidE = 0; PCSrcE = 2'd0;
    #1;
  endtask

  task automatic set_branch(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic zero, input logic pred);
    ValidE = 1; PCSrcE = 2'd2; ZeroE = zero; PredTakenE = pred;
    PCE = pc; PCPlus4E = pc + 32'd4; PCTargetE = tgt;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; StallF = 0; ValidE = 0; PCSrcE = 0; ZeroE = 0; PredTakenE = 0;
    PCE = 0; PCPlus4E = 0; PCTargetE = 0; ALUResultE = 0;
    tick(); tick();
    rst_n = 1;
    #1;
    n_cmp++; if (PCF !== RESET_PC) begin n_fail++; $display("[TB] FAIL reset_pcf: got %h expected %h", PCF, RESET_PC); end
    n_cmp++; if (PredTakenF !== 1'b0 || FlushOut !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got pred=%b flush=%b expected 0/0", PredTakenF, FlushOut); end
    n_cmp++; if (MispredictCnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d expected 0", MispredictCnt); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (PCF !== 32'(i * 4) || PredTakenF !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_pcf_%0d: got %h/%b expected %h/0", i, PCF, PredTakenF, 32'(i * 4)); end
    end
  endtask

  task automatic test_branch_taken();
    set_branch(32'h10, 32'h40, 1, 0);
    n_cmp++; if (FlushOut !== 1'b1) begin n_fail++; $display("[TB] FAIL taken_flush: got %b expected 1", FlushOut); end
    tick();
    ValidE = 0; #1;
    n_cmp++; if (PCF !== 32'h40) begin n_fail++; $display("[TB] FAIL taken_redirect: got %h expected %h", PCF, 32'h40); end
    n_cmp++; if (MispredictCnt !== 32'd1) begin n_fail++; $display("[TB] FAIL taken_cnt: got %0d expected 1", MispredictCnt); end
    redirect(32'h10);
    n_cmp++; if (PredTakenF !== 1'b1) begin n_fail++; $display("[TB] FAIL alloc_predict: got %b expected 1", PredTakenF); end
    tick();
    n_cmp++; if (PCF !== 32'h40) begin n_fail++; $display("[TB] FAIL predicted_next: got %h expected %h", PCF, 32'h40); end
  endtask

  task automatic test_counter();
    set_branch(32'h10, 32'h40, 0, 1);
    n_cmp++; if (FlushOut !== 1'b1) begin n_fail++; $display("[TB] FAIL nottaken_flush: got %b expected 1", FlushOut); end
    tick();
    ValidE = 0; #1;
    n_cmp++; if (PCF !== 32'h14) begin n_fail++; $display("[TB] FAIL nottaken_redirect: got %h expected %h", PCF, 32'h14); end
    redirect(32'h10);
    n_cmp++; if (PredTakenF !== 1'b0) begin n_fail++; $display("[TB] FAIL weak_nottaken_pred: got %b expected 0", PredTakenF); end
    set_branch(32'h10, 32'h40, 1, 1);
    for (int i = 0; i < 4; i++) tick();
    set_branch(32'h10, 32'h40, 0, 0);
    tick();
    redirect(32'h10);
    n_cmp++; if (PredTakenF !== 1'b1) begin n_fail++; $display("[TB] FAIL saturate_pred: got %b expected 1", PredTakenF); end
    set_branch(32'h10, 32'h40, 0, 0);
    tick();
    redirect(32'h10);
    n_cmp++; if (PredTakenF !== 1'b0) begin n_fail++; $display("[TB] FAIL decrement_pred: got %b expected 0", PredTakenF); end
    set_branch(32'h10, 32'h40, 1, 1);
    tick(); tick();
    ValidE = 0; #1;
  endtask

  task automatic test_jalr();
    ValidE = 1; PCSrcE = 2'd3; PredTakenE = 0; PCE = 32'h20; PCPlus4E = 32'h24;
    ALUResultE = 32'h100; PCTargetE = 32'h80;
    #1;
    n_cmp++; if (FlushOut !== 1'b1) begin n_fail++; $display("[TB] FAIL jalr_flush: got %b expected 1", FlushOut); end
    tick();
    ValidE = 0; PCSrcE = 0; #1;
    n_cmp++; if (PCF !== 32'h100) begin n_fail++; $display("[TB] FAIL jalr_target: got %h expected %h", PCF, 32'h100); end
    redirect(32'h10);
    n_cmp++; if (PredTakenF !== 1'b1) begin n_fail++; $display("[TB] FAIL jalr_no_alloc: got %b expected 1", PredTakenF); end
    n_cmp++; if (MispredictCnt !== m_cnt) begin n_fail++; $display("[TB] FAIL jalr_cnt: got %0d expected %0d", MispredictCnt, m_cnt); end
  endtask

  task automatic test_stall();
    ValidE = 1; PCSrcE = 2'd1; PredTakenE = 0; StallF = 1;
    PCE = 32'h34; PCPlus4E = 32'h38; PCTargetE = 32'h200;
    tick();
    n_cmp++; if (PCF !== 32'h200) begin n_fail++; $display("[TB] FAIL stall_redirect: got %h expected %h", PCF, 32'h200); end
    ValidE = 0; PCSrcE = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (PCF !== 32'h200) begin n_fail++; $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, PCF, 32'h200); end
    end
    StallF = 0;
    set_branch(32'h30, 32'h80, 1, 0);
    ValidE = 0; #1;
    n_cmp++; if (FlushOut !== 1'b0) begin n_fail++; $display("[TB] FAIL bubble_flush: got %b expected 0", FlushOut); end
    tick();
    n_cmp++; if (PCF !== 32'h204) begin n_fail++; $display("[TB] FAIL bubble_next: got %h expected %h", PCF, 32'h204); end
    redirect(32'h10);
    n_cmp++; if (PredTakenF !== 1'b1) begin n_fail++; $display("[TB] FAIL bubble_no_update: got %b expected 1", PredTakenF); end
  endtask

  task automatic test_alias_and_reset();
    set_branch(32'h20, 32'h60, 1, 0);
    tick();
    ValidE = 0; #1;
    redirect(32'h10);
    n_cmp++; if (PredTakenF !== 1'b0) begin n_fail++; $display("[TB] FAIL alias_evict: got %b expected 0", PredTakenF); end
    redirect(32'h20);
    n_cmp++; if (PredTakenF !== 1'b1) begin n_fail++; $display("[TB] FAIL alias_new: got %b expected 1", PredTakenF); end
    tick();
    n_cmp++; if (PCF !== 32'h60) begin n_fail++; $display("[TB] FAIL alias_target: got %h expected %h", PCF, 32'h60); end
    redirect(32'hFFFF_FFFC);
    n_cmp++; if (PCPlus4F !== 32'h0) begin n_fail++; $display("[TB] FAIL pcplus4_wrap: got %h expected 0", PCPlus4F); end
    // Reset with a live mispredict in E: reset must win.
    ValidE = 1; PCSrcE = 2'd1; PredTakenE = 0; StallF = 1; PCE = 32'h8; PCTargetE = 32'h300;
    rst_n = 0;
    tick();
    ValidE = 0; PCSrcE = 0; StallF = 0; rst_n = 1; #1;
    n_cmp++; if (PCF !== RESET_PC) begin n_fail++; $display("[TB] FAIL midrun_reset_pcf: got %h expected %h", PCF, RESET_PC); end
    n_cmp++; if (MispredictCnt !== 32'd0) begin n_fail++; $display("[TB] FAIL midrun_reset_cnt: got %0d expected 0", MispredictCnt); end
    redirect(32'h20);
    n_cmp++; if (PredTakenF !== 1'b0) begin n_fail++; $display("[TB] FAIL midrun_reset_inval_a: got %b expected 0", PredTakenF); end
    redirect(32'h34);
    n_cmp++; if (PredTakenF !== 1'b0) begin n_fail++; $display("[TB] FAIL midrun_reset_inval_b: got %b expected 0", PredTakenF); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      StallF     = ($urandom_range(0, 3) == 0);
      ValidE     = ($urandom_range(0, 3) != 0);
      PCSrcE     = 2'($urandom_range(0, 3));
      ZeroE      = 1'($urandom_range(0, 1));
      PredTakenE = 1'($urandom_range(0, 1));
      PCE        = 32'($urandom_range(0, 15)) << 2;
      PCPlus4E   = PCE + 32'd4;
      PCTargetE  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom_range(0, 15)) << 2);
      ALUResultE = ($urandom_range(0, 1) == 0) ? 32'($urandom) : (32'($urandom_range(0, 15)) << 2);
      #1;
      n_cmp++; if (PCF !== m_pc || PCPlus4F !== m_pc + 32'd4) begin n_fail++; $display("[TB] FAIL rand_pc cycle %0d: got %h/%h expected %h/%h", c, PCF, PCPlus4F, m_pc, m_pc + 32'd4); end
      n_cmp++; if (PredTakenF !== m_pred() || FlushOut !== m_flush()) begin n_fail++; $display("[TB] FAIL rand_flags cycle %0d: got pred=%b flush=%b expected pred=%b flush=%b", c, PredTakenF, FlushOut, m_pred(), m_flush()); end
      n_cmp++; if (MispredictCnt !== m_cnt) begin n_fail++; $display("[TB] FAIL rand_cnt cycle %0d: got %0d expected %0d", c, MispredictCnt, m_cnt); end
      tick();
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    m_pc = RESET_PC;
    m_cnt = 0;
    test_reset();
    test_branch_taken();
    test_counter();
    test_jalr();
    test_stall();
    test_alias_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Next-generation fetch PC generator; replaces the combinational next-PC select with a registered PC plus a direct-mapped branch target buffer (BTB) carrying 2-bit saturating counters.
- Predicts in F, resolves in E, redirects and flushes on misprediction.
- Sits between the fetch PC register site and instruction memory. The execute stage feeds resolution data back.

Parameters:
- WIDTH, 32, address/data width.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2. IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, PCF value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- StallF  in  1  hold PCF (hazard unit).
- ValidE  in  1  E-stage holds a real instruction (not a bubble).
- PCSrcE  in  2  00 seq, 01 JAL, 10 conditional branch, 11 JALR.
- ZeroE  in  1  branch condition result in E.
- PCE  in  WIDTH  PC of the E instruction.
- PCPlus4E  in  WIDTH  PCE+4.
- PCTargetE  in  WIDTH  PCE+imm.
- ALUResultE  in  WIDTH  JALR target.
- PredTakenE  in  1  PredTakenF carried down the pipeline with the instruction.
- PCF  out  WIDTH  current fetch PC.
- PCPlus4F  out  WIDTH  PCF+4.
- PredTakenF  out  1  prediction made for PCF.
- FlushOut  out  1  misprediction in E; flush F/D and D/E.
- MispredictCnt  out  32  saturating misprediction count.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - PCF=RESET_PC.
  - All BTB valid bits=0.
  - MispredictCnt=0.
  - Outputs otherwise derive combinationally, so PredTakenF=0 and FlushOut=0 unless E inputs say otherwise.
  - Reset overrides stall and redirect.
- BTB entry: valid, tag = PC[WIDTH-1:IDX+2], target[WIDTH-1:0], ctr[1:0]. Index = PC[IDX+1:2]. PC[1:0] is ignored.
- F lookup is combinational on PCF: hit = valid & tag match. PredTakenF = hit & ctr[1]. Predicted next = PredTakenF ? target : PCPlus4F.
- E resolution is active only when ValidE=1:
  - TakenE = (PCSrcE==01) | (PCSrcE==10 & ZeroE) | (PCSrcE==11).
  - Actual target = ALUResultE for JALR, else PCTargetE.
  - Mispredict = TakenE != PredTakenE.
  - JALR is never entered in the BTB, so a taken JALR always mispredicts.
  - FlushOut = Mispredict & ValidE (combinational).
- Next-PC priority, highest first:
  1. FlushOut: load the correct PC (target if TakenE, else PCPlus4E). StallF is ignored.
  2. StallF: hold PCF.
  3. Otherwise: load the predicted next PC.
- BTB update happens at the clk edge when ValidE and PCSrcE is 01 or 10:
  - Hit on PCE: ctr increments (sat 11) if TakenE, decrements (sat 00) otherwise. Target is rewritten with PCTargetE.
  - Miss and TakenE: allocate and overwrite the entry with valid=1, tag, target=PCTargetE, ctr=10.
  - Miss and not taken: no change.
  - Update is independent of StallF.
- Same index read in F and written in the same cycle: F sees the old contents; the new value is visible the next cycle.
- PCSrcE=00 or ValidE=0: no BTB change and no flush.
- MispredictCnt increments on each FlushOut cycle and saturates at 32'hFFFF_FFFF.
- Width rules: PCPlus4F wraps modulo 2^WIDTH.
- A misaligned target is passed through unchanged; BTB indexing ignores bits [1:0].

Test Plan:
1. Reset, then run 3 cycles without stall: PCF goes 0 -> 4 -> 8 -> C. PredTakenF=0. MispredictCnt=0.
2. Conditional branch at PCE=0x10, PCTargetE=0x40, ZeroE=1, PredTakenE=0, ValidE=1:
   - FlushOut=1 and next PCF=0x40.
   - Entry[4] becomes valid, ctr=10.
   - Later fetch of 0x10 gives PredTakenF=1 and next PCF=0x40.
3. Same branch resolves not-taken with PredTakenE=1:
   - FlushOut=1, next PCF=0x14, ctr 10 -> 01.
   - Next fetch of 0x10 gives PredTakenF=0.
   - Four taken resolutions saturate ctr at 11.
4. JALR at PCE=0x20, ALUResultE=0x100, PredTakenE=0: FlushOut=1, PCF=0x100, BTB unchanged.
5. StallF=1 together with a mispredict: PCF takes the redirect. StallF=1 alone for 2 cycles: PCF holds its value. ValidE=0 with PCSrcE=10, ZeroE=1: no flush and no update.
6. Aliasing with BTB_ENTRIES=4: a taken branch at 0x10 then a taken branch at 0x20 (same index 0, different tag). The 0x20 allocation replaces the entry, so a fetch of 0x10 misses with PredTakenF=0. Assert rst_n=0 mid-run: PCF=RESET_PC, all entries invalid, MispredictCnt=0.
